i2s_dac_serializer: RTL and testbench

- Output stage directly downstream of the voice volume mixer.
- Captures the mixer's left/right sample words on a one-cycle strobe and double-buffers them.
- Generates BCLK and LRCK from the synth clock by integer division.
- Shifts the samples out MSB-first in standard I2S framing to the codec DAC, with over/underrun status for the host.

---
 rtl/i2s_dac_serializer.sv | 126 ++++++++++++
 tb/tb_i2s_dac_serializer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/i2s_dac_serializer.sv
// rtl/i2s_dac_serializer.sv - I2S DAC output stage with double-buffered L/R samples.
// BCLK/LRCK by integer division; MSB-first data with one-bit delay; sticky overrun/underrun.
module i2s_dac_serializer #(
  parameter int AUD_BIT_DEPTH = 24,
  parameter int SLOT_BITS     = 32,
  parameter int BCLK_DIV      = 4
) (
  input  logic                     sCLK_XVXENVS,
  input  logic                     reset_reg_N,
  input  logic                     sample_stb,
  input  logic [AUD_BIT_DEPTH-1:0] lsound_in,
  input  logic [AUD_BIT_DEPTH-1:0] rsound_in,
  input  logic                     status_clr,
  output logic                     AUD_BCLK,
  output logic                     AUD_DACLRCK,
  output logic                     AUD_DACDAT,
  output logic                     frame_start,
  output logic                     overrun,
  output logic                     underrun
);
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] SLOT_N   = BW'(SLOT_BITS);
  localparam logic [BW-1:0] DEPTH_N  = BW'(AUD_BIT_DEPTH);

  logic [DW-1:0]            div_cnt_q, div_cnt_d;
  logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
  logic                     bclk_q, bclk_d, lrck_q, lrck_d, dat_q, dat_d;
  logic [AUD_BIT_DEPTH-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [AUD_BIT_DEPTH-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
  logic                     pend_valid_q, pend_valid_d;
  logic                     overrun_q, overrun_d, underrun_q, underrun_d;

  logic                     wrap, fall, frame_load, ovr_set, und_set;
  logic [BW-1:0]            slot_idx;
  logic [AUD_BIT_DEPTH-1:0] word, shifted;

  always_comb begin
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    bclk_d       = bclk_q;
    lrck_d       = lrck_q;
    dat_d        = dat_q;
    pend_l_d     = pend_l_q;
    pend_r_d     = pend_r_q;
    act_l_d      = act_l_q;
    act_r_d      = act_r_q;
    pend_valid_d = pend_valid_q;
    slot_idx     = '0;
    word         = '0;
    shifted      = '0;

    wrap       = (div_cnt_q == DIV_LAST);
    fall       = wrap && bclk_q;
    frame_load = fall && (bit_cnt_q == BIT_LAST);
    ovr_set    = sample_stb && pend_valid_q && !frame_load;
    und_set    = frame_load && !pend_valid_q;

    div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
    if (wrap) bclk_d = ~bclk_q;

    // Load uses the old pending word, so a coincident strobe lands in pending.
    if (frame_load && pend_valid_q) begin
      act_l_d = pend_l_q;
      act_r_d = pend_r_q;
    end
    if (sample_stb) begin
      pend_l_d     = lsound_in;
      pend_r_d     = rsound_in;
      pend_valid_d = 1'b1;
    end else if (frame_load) begin
      pend_valid_d = 1'b0;
    end

    if (fall) begin
      bit_cnt_d = frame_load ? '0 : bit_cnt_q + 1'b1;
      lrck_d    = (bit_cnt_d >= SLOT_N);
      slot_idx  = lrck_d ? bit_cnt_d - SLOT_N : bit_cnt_d;
      word      = lrck_d ? act_r_d : act_l_d;
      shifted   = word >> (DEPTH_N - slot_idx);
      dat_d     = (slot_idx != '0) && (slot_idx <= DEPTH_N) && shifted[0];
    end

    overrun_d  = ovr_set || (overrun_q && !status_clr);
    underrun_d = und_set || (underrun_q && !status_clr);
  end

  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      bclk_q       <= 1'b0;
      lrck_q       <= 1'b0;
      dat_q        <= 1'b0;
      pend_l_q     <= '0;
      pend_r_q     <= '0;
      act_l_q      <= '0;
      act_r_q      <= '0;
      pend_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      bclk_q       <= bclk_d;
      lrck_q       <= lrck_d;
      dat_q        <= dat_d;
      pend_l_q     <= pend_l_d;
      pend_r_q     <= pend_r_d;
      act_l_q      <= act_l_d;
      act_r_q      <= act_r_d;
      pend_valid_q <= pend_valid_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
    end
  end

  assign AUD_BCLK    = bclk_q;
  assign AUD_DACLRCK = lrck_q;
  assign AUD_DACDAT  = dat_q;
  assign frame_start = frame_load;
  assign overrun     = overrun_q;
  assign underrun    = underrun_q;
endmodule

// File: tb/tb_i2s_dac_serializer.sv
// tb/tb_i2s_dac_serializer.sv - directed self-checking bench for i2s_dac_serializer.
module tb_i2s_dac_serializer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_stb = 1'b0;
  logic [23:0] lsound_in = '0;
  logic [23:0] rsound_in = '0;
  logic        status_clr = 1'b0;
  logic        bclk, lrck, dat, frame_start, overrun, underrun;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] cap_dat, cap_lr, cap_bclk;

  i2s_dac_serializer #(.AUD_BIT_DEPTH(24), .SLOT_BITS(32), .BCLK_DIV(4)) dut (
    .sCLK_XVXENVS(clk),
    .reset_reg_N (rst_n),
    .sample_stb  (sample_stb),
    .lsound_in   (lsound_in),
    .rsound_in   (rsound_in),
    .status_clr  (status_clr),
    .AUD_BCLK    (bclk),
    .AUD_DACLRCK (lrck),
    .AUD_DACDAT  (dat),
    .frame_start (frame_start),
    .overrun     (overrun),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] frame_bits(input logic [23:0] l, input logic [23:0] r);
    return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
  endfunction

  // Returns at a negedge with frame_start high (load happens at the next posedge).
  task automatic wait_frame_start(input string tag);
    int found = 0;
    for (int c = 0; c < 600 && found == 0; c++) begin
      @(negedge clk);
      if (frame_start === 1'b1) found = 1;
    end
    if (found == 0) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic capture_frame(input logic do_stb, input logic [23:0] l, input logic [23:0] r);
    if (do_stb) begin
      sample_stb = 1'b1;
      lsound_in  = l;
      rsound_in  = r;
    end
    @(posedge clk); #1;
    sample_stb = 1'b0;
    cap_dat[63] = dat; cap_lr[63] = lrck; cap_bclk[63] = bclk;
    for (int i = 1; i < 64; i++) begin
      repeat (8) @(posedge clk);
      #1;
      cap_dat[63-i] = dat; cap_lr[63-i] = lrck; cap_bclk[63-i] = bclk;
    end
  endtask

  task automatic check_frame(input string tag, input logic [63:0] exp);
    check({tag, "_dat"}, cap_dat, exp);
    check({tag, "_lrck"}, cap_lr, {32'h0, 32'hFFFF_FFFF});
    check({tag, "_bclk"}, cap_bclk, 64'd0);
  endtask

  initial begin
    // 1: reset and first-frame timing
    repeat (20) @(posedge clk);
    #1;
    check("rst_outs", {58'd0, bclk, lrck, dat, frame_start, overrun, underrun}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 512; c++) begin
      @(posedge clk); #1;
      if (c == 3)   check("bclk_c3", {63'd0, bclk}, 64'd0);
      if (c == 4)   check("bclk_c4", {63'd0, bclk}, 64'd1);
      if (c == 7)   check("bclk_c7", {63'd0, bclk}, 64'd1);
      if (c == 8)   check("bclk_c8", {63'd0, bclk}, 64'd0);
      if (c == 255) check("lrck_c255", {63'd0, lrck}, 64'd0);
      if (c == 256) check("lrck_c256", {63'd0, lrck}, 64'd1);
      if (c == 510) check("fs_c510", {63'd0, frame_start}, 64'd0);
      if (c == 511) check("fs_c511", {63'd0, frame_start}, 64'd1);
      if (c == 512) check("und_first", {62'd0, overrun, underrun}, 64'd1);
    end

    // 2: normal frame
    @(negedge clk); status_clr = 1'b1;
    @(negedge clk); status_clr = 1'b0;
    check("und_clr1", {63'd0, underrun}, 64'd0);
    sample_stb = 1'b1; lsound_in = 24'hA5A5A5; rsound_in = 24'h5A5A5A;
    @(negedge clk); sample_stb = 1'b0;
    wait_frame_start("f2");
    capture_frame(1'b0, 24'h0, 24'h0);
    check_frame("f2", frame_bits(24'hA5A5A5, 24'h5A5A5A));
    check("f2_flags", {62'd0, overrun, underrun}, 64'd0);

    // 3: underrun repeats last sample
    wait_frame_start("f3");
    capture_frame(1'b0, 24'h0, 24'h0);
    check_frame("f3", frame_bits(24'hA5A5A5, 24'h5A5A5A));
    check("f3_flags", {62'd0, overrun, underrun}, 64'd1);
    @(negedge clk); status_clr = 1'b1;
    @(negedge clk); status_clr = 1'b0;
    check("und_clr2", {63'd0, underrun}, 64'd0);

    // 4: overrun keeps only the newest sample
    sample_stb = 1'b1; lsound_in = 24'h000001; rsound_in = 24'h000001;
    @(negedge clk); lsound_in = 24'h7FFFFF; rsound_in = 24'h800000;
    @(negedge clk); sample_stb = 1'b0;
    check("ovr_set", {62'd0, overrun, underrun}, 64'd2);
    wait_frame_start("f4");
    capture_frame(1'b0, 24'h0, 24'h0);
    check_frame("f4", frame_bits(24'h7FFFFF, 24'h800000));
    check("f4_flags", {62'd0, overrun, underrun}, 64'd2);

    // 5: strobe coincident with frame load
    @(negedge clk); status_clr = 1'b1;
    @(negedge clk); status_clr = 1'b0;
    sample_stb = 1'b1; lsound_in = 24'hABCDEF; rsound_in = 24'hFEDCBA;
    @(negedge clk); sample_stb = 1'b0;
    check("f5_pre_flags", {62'd0, overrun, underrun}, 64'd0);
    wait_frame_start("f5");
    capture_frame(1'b1, 24'h123456, 24'h654321);
    check_frame("f5", frame_bits(24'hABCDEF, 24'hFEDCBA));
    check("f5_flags", {62'd0, overrun, underrun}, 64'd0);
    wait_frame_start("f6");
    capture_frame(1'b0, 24'h0, 24'h0);
    check_frame("f6", frame_bits(24'h123456, 24'h654321));
    check("f6_flags", {62'd0, overrun, underrun}, 64'd0);

    // set event wins over a same-cycle clear
    @(negedge clk); sample_stb = 1'b1; lsound_in = 24'h111111; rsound_in = 24'h222222;
    @(negedge clk); lsound_in = 24'h0F0F0F; rsound_in = 24'hFFFFFF; status_clr = 1'b1;
    @(negedge clk); sample_stb = 1'b0; status_clr = 1'b0;
    check("ovr_set_vs_clr", {63'd0, overrun}, 64'd1);
    @(negedge clk); status_clr = 1'b1;
    @(negedge clk); status_clr = 1'b0;
    check("ovr_clr", {63'd0, overrun}, 64'd0);

    // 6: asynchronous reset mid right slot
    wait_frame_start("f7");
    @(posedge clk);
    repeat (320) @(posedge clk);
    repeat (4) @(posedge clk);
    #2;
    check("pre_rst_outs", {61'd0, bclk, lrck, dat}, 64'd7);
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", {58'd0, bclk, lrck, dat, frame_start, overrun, underrun}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_frame_start("f8");
    capture_frame(1'b0, 24'h0, 24'h0);
    check_frame("f8", 64'd0);
    check("f8_flags", {62'd0, overrun, underrun}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
